sti_serial_packer: RTL and testbench



---
 rtl/sti_serial_packer.sv | 124 ++++++++++++
 tb/tb_sti_serial_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_serial_packer.sv
// Serial bit stream to DATA_W-bit word packer with sequential memory writes.
// Define STI_PACKER_PAD_EN to zero-fill the rest of memory before done.
module sti_serial_packer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic              si_end,
  input  logic              si_msb_first,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef STI_PACKER_PAD_EN
  typedef enum logic [2:0] {IDLE, RECV, FLUSH, PAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, FLUSH, DONE} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sreg;
  logic              msb;

  logic              m;
  logic [CW-1:0]     idx;
  logic [DATA_W-1:0] nword;
  logic [DATA_W-1:0] word;
  logic              full;
  logic              hold;
  logic              rx;
  logic              fin;
  logic [ADDR_W-1:0] a_nx;

  // Bits are dropped straight into their final position, so a
  // cleared sreg gives zero fill for a partial word at flush.
  always_comb begin
    m     = (cnt == '0) ? si_msb_first : msb;
    idx   = m ? (CW'(DATA_W - 1) - cnt) : cnt;
    nword = sreg;
    nword[idx] = si_data;
    word  = si_valid ? nword : sreg;
    full  = si_valid && (cnt == CW'(DATA_W - 1));
    hold  = si_valid || (cnt != '0);
    rx    = (state == IDLE) || (state == RECV);
    fin   = (rx && si_end && !hold)
         || (state != IDLE && state != RECV
             && state != DONE);
    a_nx  = wr_en ? (wr_addr + 1'b1) : wr_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg    <= '0;
      msb     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      done    <= 1'b0;
      wr_addr <= a_nx;
      unique case (state)
        IDLE, RECV: begin
          if (si_valid) begin
            busy  <= 1'b1;
            state <= RECV;
            if (cnt == '0)
              msb <= si_msb_first;
            if (full) begin
              cnt     <= '0;
              sreg    <= '0;
              wr_en   <= 1'b1;
              wr_data <= nword;
            end else begin
              cnt  <= cnt + 1'b1;
              sreg <= nword;
            end
          end
          if (si_end) begin
            cnt  <= '0;
            sreg <= '0;
            if (hold) begin
              state   <= FLUSH;
              wr_en   <= 1'b1;
              wr_data <= word;
            end
          end
        end
        DONE: state <= IDLE;
        default: ;
      endcase
      // Final write (or none) is behind us: pad or finish.
      if (fin) begin
`ifdef STI_PACKER_PAD_EN
        if (a_nx != '0) begin
          state   <= PAD;
          wr_en   <= 1'b1;
          wr_data <= '0;
        end else
`endif
        begin
          state   <= DONE;
          done    <= 1'b1;
          busy    <= 1'b0;
          wr_addr <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sti_serial_packer.sv
// Randomised and directed bench for sti_serial_packer against a
// transaction-level model of expected writes and done timing.
module tb_sti_serial_packer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          si_data;
  logic          si_valid;
  logic          si_end;
  logic          si_msb_first;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int pcount = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  bits[$];
  int  wmsb;
  int  maddr;
  int  last_wr;
  int  last_exp;
  wr_t mon_e;
  int  n;
  bit  tog;

  sti_serial_packer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .si_data(si_data),
    .si_valid(si_valid),
    .si_end(si_end),
    .si_msb_first(si_msb_first),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcount <= pcount + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int word_val();
    int v;
    v = 0;
    foreach (bits[i])
      if (bits[i] != 0)
        v += (wmsb != 0) ? (1 << (DW - 1 - i)) : (1 << i);
    return v;
  endfunction

  task automatic push_wr(input int data, input int cyc);
    wr_t e;
    e.addr = maddr;
    e.data = data;
    e.cyc  = cyc;
    wq.push_back(e);
    maddr   = (maddr + 1) % DEPTH;
    last_wr = cyc;
  endtask

  function automatic int after(input int c);
    return (last_wr + 1 > c + 1) ? last_wr + 1 : c + 1;
  endfunction

  // One input cycle; the model is advanced from the same values.
  task automatic step(input bit v, input bit d,
                      input bit e, input bit m);
    int c;
    @(negedge clk);
    si_valid     = v;
    si_data      = d;
    si_end       = e;
    si_msb_first = m;
    c = pcount;
    if (v) begin
      if (bits.size() == 0) wmsb = int'(m);
      bits.push_back(int'(d));
      if (bits.size() == DW) begin
        push_wr(word_val(), c + 1);
        bits.delete();
      end
    end
    if (e) begin
      if (bits.size() != 0) begin
        push_wr(word_val(), c + 1);
        bits.delete();
      end
`ifdef STI_PACKER_PAD_EN
      while (maddr != 0) push_wr(0, after(c));
`endif
      dq.push_back(after(c));
      maddr = 0;
    end
  endtask

  task automatic send_bits(input logic [31:0] pat,
                           input int nb, input bit m);
    for (int i = nb - 1; i >= 0; i--)
      step(1'b1, pat[i], 1'b0, m);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0,
           1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((wq.size() != 0 || dq.size() != 0) && k < 60) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      k++;
    end
    chk("drain_left", wq.size() + dq.size(), 0);
  endtask

  task automatic end_stream();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    drain();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_exp = 0;
    end else begin
      if (wr_en) begin
        chk("wr_busy", busy, 1);
        if (wq.size() == 0) begin
          chk("wr_unexpected", wr_addr, 32'hffff_ffff);
        end else begin
          mon_e = wq.pop_front();
          chk("wr_cyc", pcount, mon_e.cyc);
          chk("wr_addr", wr_addr, mon_e.addr);
          chk("wr_data", wr_data, mon_e.data);
          last_exp = mon_e.data;
        end
      end else begin
        chk("wr_hold", wr_data, last_exp);
      end
      if (done) begin
        chk("done_busy", busy, 0);
        chk("done_addr", wr_addr, 0);
        if (dq.size() == 0)
          chk("done_unexpected", pcount, 32'hffff_ffff);
        else
          chk("done_cyc", pcount, dq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    si_valid = 1'b0;
    si_data = 1'b0;
    si_end = 1'b0;
    si_msb_first = 1'b0;
    maddr = 0;
    last_wr = -10;
    wmsb = 0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    send_bits(32'hC1, 8, 1'b1);
    idle(2);
    send_bits(32'hC1, 8, 1'b0);
    send_bits(32'h0F, 8, 1'b1);
    send_bits(32'hB, 4, 1'b1);
    idle(5);
    send_bits(32'h2, 4, 1'b0);
    end_stream();

    send_bits(32'h7, 3, 1'b1);
    end_stream();

    send_bits(32'h5A, 8, 1'b1);
    end_stream();

    for (int w = 0; w < DEPTH; w++)
      send_bits($urandom_range(0, 255), 8, 1'($urandom_range(0, 1)));
    end_stream();

    for (int w = 0; w < DEPTH + 2; w++)
      send_bits($urandom_range(0, 255), 8, 1'($urandom_range(0, 1)));
    send_bits(32'h1, 1, 1'b0);
    end_stream();

    end_stream();

    send_bits(32'h15, 5, 1'b1);
    @(negedge clk);
    si_valid = 1'b0;
    si_end = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    bits.delete();
    wq.delete();
    dq.delete();
    maddr = 0;
    @(negedge clk);
    reset = 1'b0;
    send_bits(32'h3C, 8, 1'b0);
    end_stream();

    for (int s = 0; s < 40; s++) begin
      n = $urandom_range(0, 40);
      tog = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0)
          idle(1);
        step(1'b1, 1'($urandom_range(0, 1)),
             (i == n - 1) && tog, 1'($urandom_range(0, 1)));
      end
      if (n > 0 && tog) begin
        drain();
      end else begin
        idle($urandom_range(0, 2));
        end_stream();
      end
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
